muldiv_unit: RTL and testbench

- Iterative RV32M multiply/divide execution unit for the RISC-V microcontroller datapath.
- Consumes the two source operands read from the register file (RD1/RD2) plus the destination index.
- Runs a multi-cycle shift-add multiply or restoring divide.
- Presents a one-cycle `done` pulse with `result`/`rd_out`, which drive the register-file write port (WD3/A3/WE3) in the writeback path.

---
 rtl/muldiv_unit.sv | 164 ++++++++++++++++
 tb/tb_muldiv_unit.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: 32-step shift-add multiply, restoring divide.
// Optional MULDIV_FAST_MUL_EN: single-cycle combinational multiply; divides stay iterative.
module muldiv_unit (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        kill,
    input  logic [2:0]  funct3,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    input  logic [4:0]  rd,
    output logic        busy,
    output logic        done,
    output logic [31:0] result,
    output logic [4:0]  rd_out
);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t      state_q, state_d;
    logic [5:0]  cnt_q;

    logic [2:0]  f3_q;
    logic [4:0]  rd_q;
    logic [31:0] a_q, b_q;
    logic        neg_q;
    logic        bzero_q;
    logic [63:0] work_q;
    logic [31:0] rem_q;

    logic        load;
    logic        last_iter;
    logic        fast_mul;

    // Operand decode for the incoming request
    logic        in_div, a_signed, b_signed, sa, sb, neg_d;
    logic [31:0] a_mag, b_mag;

    always_comb begin
        in_div   = funct3[2];
        a_signed = in_div ? ~funct3[0] : (funct3[1:0] != 2'b11);
        b_signed = in_div ? ~funct3[0] : ~funct3[1];
        sa       = a_signed & op_a[31];
        sb       = b_signed & op_b[31];
        a_mag    = sa ? -op_a : op_a;
        b_mag    = sb ? -op_b : op_b;
        // Remainder takes the dividend's sign; product and quotient take the XOR.
        neg_d    = (in_div & funct3[1]) ? sa : (sa ^ sb);
    end

`ifdef MULDIV_FAST_MUL_EN
    assign fast_mul = ~f3_q[2];
`else
    assign fast_mul = 1'b0;
`endif

    assign load      = start && !kill && (state_q != CALC);
    assign last_iter = (state_q == CALC) && (fast_mul || (cnt_q == 6'd31));

    // NOTE: every always_comb output gets a default first so no path infers a latch.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE:    if (load) state_d = CALC;
            CALC:    if (last_iter) state_d = DONE;
            DONE:    state_d = load ? CALC : IDLE;
            default: state_d = IDLE;
        endcase
        if (kill) state_d = IDLE;
    end

    assign busy = (state_q == CALC);
    assign done = (state_q == DONE);

    // One iteration of each core, plus final sign correction
    logic [32:0] mul_sum;
    logic [63:0] mul_next;
    logic [63:0] product;
    logic [63:0] prod_fix;
    logic [32:0] rem_shift;
    logic        rem_ge;
    logic [31:0] rem_sub;
    logic [31:0] rem_next;
    logic [31:0] quo_next;
    logic [31:0] quo_fix;
    logic [31:0] rem_fix;
    logic [31:0] result_d;
`ifdef MULDIV_FAST_MUL_EN
    logic [63:0] prod_fast;
`endif

    always_comb begin
        mul_sum   = {1'b0, work_q[63:32]} + (work_q[0] ? {1'b0, a_q} : 33'd0);
        mul_next  = {mul_sum, work_q[31:1]};

        // rem_shift[32] is the guard bit; the subtract only happens when it cannot borrow.
        rem_shift = {rem_q, work_q[31]};
        rem_ge    = (rem_shift >= {1'b0, b_q});
        rem_sub   = rem_shift[31:0] - b_q;
        rem_next  = rem_ge ? rem_sub : rem_shift[31:0];
        quo_next  = {work_q[30:0], rem_ge};

`ifdef MULDIV_FAST_MUL_EN
        prod_fast = 64'($signed({1'b0, a_q}) * $signed({1'b0, b_q}));
        product   = fast_mul ? prod_fast : mul_next;
`else
        product   = mul_next;
`endif
        prod_fix  = neg_q ? -product : product;
        quo_fix   = bzero_q ? 32'hFFFF_FFFF : (neg_q ? -quo_next : quo_next);
        rem_fix   = neg_q ? -rem_next : rem_next;

        if (f3_q[2])
            result_d = f3_q[1] ? rem_fix : quo_fix;
        else
            result_d = (f3_q[1:0] == 2'b00) ? prod_fix[31:0] : prod_fix[63:32];
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= 6'd0;
            result  <= 32'd0;
            rd_out  <= 5'd0;
        end else begin
            state_q <= state_d;
            if (load)
                cnt_q <= 6'd0;
            else if (state_q == CALC)
                cnt_q <= cnt_q + 6'd1;
            if (last_iter && !kill) begin
                result <= result_d;
                rd_out <= rd_q;
            end
        end
    end

    // NOTE: datapath registers carry no reset; they are always loaded before being read.
    always_ff @(posedge clk) begin
        if (load) begin
            f3_q    <= funct3;
            rd_q    <= rd;
            a_q     <= a_mag;
            b_q     <= b_mag;
            neg_q   <= neg_d;
            bzero_q <= (op_b == 32'd0);
            work_q  <= {32'd0, in_div ? a_mag : b_mag};
            rem_q   <= 32'd0;
        end else if (state_q == CALC) begin
            if (f3_q[2]) begin
                work_q <= {work_q[63:32], quo_next};
                rem_q  <= rem_next;
            end else begin
                work_q <= mul_next;
            end
        end
    end

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed cases, control scenarios and random ops
// checked against an arithmetic reference model.
module tb_muldiv_unit;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic        kill = 1'b0;
    logic [2:0]  funct3 = 3'd0;
    logic [31:0] op_a = 32'd0;
    logic [31:0] op_b = 32'd0;
    logic [4:0]  rd = 5'd0;
    logic        busy, done;
    logic [31:0] result;
    logic [4:0]  rd_out;

    int checks = 0;
    int errors = 0;
    logic [31:0] last_result = 32'd0;
    logic [4:0]  last_rd = 5'd0;

`ifdef MULDIV_FAST_MUL_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    muldiv_unit dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .kill   (kill),
        .funct3 (funct3),
        .op_a   (op_a),
        .op_b   (op_b),
        .rd     (rd),
        .busy   (busy),
        .done   (done),
        .result (result),
        .rd_out (rd_out)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Reference: RV32M semantics computed with 64-bit integer arithmetic.
    function automatic logic [31:0] ref_model(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
        longint sa, sb, ua, ub;
        logic [63:0] p;
        bit ovf;
        sa  = longint'($signed(a));
        sb  = longint'($signed(b));
        ua  = longint'(a);
        ub  = longint'(b);
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        p   = 64'd0;
        case (f)
            3'd0: begin p = sa * sb; return p[31:0];  end
            3'd1: begin p = sa * sb; return p[63:32]; end
            3'd2: begin p = sa * ub; return p[63:32]; end
            3'd3: begin p = ua * ub; return p[63:32]; end
            3'd4: begin
                if (b == 0) return 32'hFFFF_FFFF;
                if (ovf) return 32'h8000_0000;
                p = sa / sb; return p[31:0];
            end
            3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
            3'd6: begin
                if (b == 0) return a;
                if (ovf) return 32'd0;
                p = sa % sb; return p[31:0];
            end
            default: return (b == 0) ? a : a % b;
        endcase
    endfunction

    function automatic int lat(input logic [2:0] f);
        return (f[2] || !FAST) ? 32 : 1;
    endfunction

    // Presents a request for one edge; returns at the falling edge after the start edge.
    task automatic launch(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b, input logic [4:0] r);
        @(negedge clk);
        start = 1'b1; kill = 1'b0;
        funct3 = f; op_a = a; op_b = b; rd = r;
        @(negedge clk);
        start = 1'b0;
        funct3 = 3'($urandom); op_a = $urandom; op_b = $urandom; rd = 5'($urandom);
    endtask

    // Counts edges until done is seen; -1 when no pulse within the budget.
    task automatic wait_done(output int k);
        k = -1;
        for (int i = 1; i <= 80; i++) begin
            @(negedge clk);
            if (done) begin
                k = i;
                break;
            end
        end
    endtask

    task automatic run_op(input string tag, input logic [2:0] f, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] r, input logic [31:0] exp);
        int k;
        launch(f, a, b, r);
        check({tag, " busy"}, 64'(busy), 64'd1);
        wait_done(k);
        check({tag, " latency"}, 64'(k), 64'(lat(f)));
        if (k > 0) begin
            check({tag, " result"}, 64'(result), 64'(exp));
            check({tag, " rd_out"}, 64'(rd_out), 64'(r));
            last_result = exp;
            last_rd     = r;
            @(negedge clk);
            check({tag, " pulse"}, 64'(done), 64'd0);
        end
    endtask

    initial begin
        int k;
        logic [2:0]  f;
        logic [31:0] a, b;
        logic [31:0] exp2;

        // Reset held for two edges
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst busy", 64'(busy), 64'd0);
        check("rst done", 64'(done), 64'd0);
        check("rst result", 64'(result), 64'd0);
        check("rst rd_out", 64'(rd_out), 64'd0);

        // Multiply family
        run_op("mul",    3'd0, 32'hFFFF_FFFF, 32'h2, 5'd5, 32'hFFFF_FFFE);
        run_op("mulh",   3'd1, 32'hFFFF_FFFF, 32'h2, 5'd5, 32'hFFFF_FFFF);
        run_op("mulhsu", 3'd2, 32'hFFFF_FFFF, 32'h2, 5'd5, 32'hFFFF_FFFF);
        run_op("mulhu",  3'd3, 32'hFFFF_FFFF, 32'h2, 5'd5, 32'h0000_0001);

        // Divide family and special cases
        run_op("div -7/2",  3'd4, 32'hFFFF_FFF9, 32'd2, 5'd1, 32'hFFFF_FFFD);
        run_op("rem -7/2",  3'd6, 32'hFFFF_FFF9, 32'd2, 5'd2, 32'hFFFF_FFFF);
        run_op("divu 100/7", 3'd5, 32'd100, 32'd7, 5'd3, 32'd14);
        run_op("remu 100/7", 3'd7, 32'd100, 32'd7, 5'd4, 32'd2);
        run_op("div x/0",   3'd4, 32'd12345, 32'd0, 5'd6, 32'hFFFF_FFFF);
        run_op("remu x/0",  3'd7, 32'h1234, 32'd0, 5'd7, 32'h1234);
        run_op("div ovf",   3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8, 32'h8000_0000);
        run_op("rem ovf",   3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 5'd0, 32'd0);

        // Kill in the 10th CALC cycle
        launch(3'd5, 32'd1000, 32'd3, 5'd9);
        repeat (9) @(negedge clk);
        kill = 1'b1;
        @(negedge clk);
        kill = 1'b0;
        check("kill busy", 64'(busy), 64'd0);
        wait_done(k);
        check("kill no done", 64'(k), 64'(-1));
        check("kill result", 64'(result), 64'(last_result));
        check("kill rd_out", 64'(rd_out), 64'(last_rd));

        // Start and kill together
        @(negedge clk);
        start = 1'b1; kill = 1'b1; funct3 = 3'd4; op_a = 32'd50; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0; kill = 1'b0;
        check("start+kill busy", 64'(busy), 64'd0);
        wait_done(k);
        check("start+kill no done", 64'(k), 64'(-1));

        // Back-to-back: restart in the DONE cycle; a start while busy is dropped
        launch(3'd5, 32'd1000, 32'd7, 5'd10);
        wait_done(k);
        check("b2b first latency", 64'(k), 64'd32);
        check("b2b first result", 64'(result), 64'd142);
        start = 1'b1; funct3 = 3'd6; op_a = 32'hFFFF_FF9C; op_b = 32'd7; rd = 5'd11;
        @(negedge clk);
        start = 1'b0;
        check("b2b second busy", 64'(busy), 64'd1);
        repeat (5) @(negedge clk);
        start = 1'b1; funct3 = 3'd5; op_a = 32'd9; op_b = 32'd3; rd = 5'd12;
        @(negedge clk);
        start = 1'b0;
        wait_done(k);
        check("b2b spacing", 64'(k + 7), 64'd33);
        check("b2b second result", 64'(result), 64'hFFFF_FFFE);
        check("b2b second rd_out", 64'(rd_out), 64'd11);
        last_result = 32'hFFFF_FFFE;
        last_rd     = 5'd11;
        wait_done(k);
        check("busy start dropped", 64'(k), 64'(-1));

        // Reset during CALC
        launch(3'd4, 32'd77, 32'd4, 5'd13);
        repeat (5) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check("mid-rst busy", 64'(busy), 64'd0);
        check("mid-rst result", 64'(result), 64'd0);
        check("mid-rst rd_out", 64'(rd_out), 64'd0);
        wait_done(k);
        check("mid-rst no done", 64'(k), 64'(-1));

        // Random operations, biased toward divide corner cases
        for (int n = 0; n < 150; n++) begin
            f = 3'($urandom_range(0, 7));
            a = $urandom;
            b = $urandom;
            case ($urandom_range(0, 9))
                0: b = 32'd0;
                1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
                2: b = $urandom_range(1, 15);
                3: a = $urandom_range(0, 255);
                default: ;
            endcase
            exp2 = ref_model(f, a, b);
            run_op("rand", f, a, b, 5'($urandom), exp2);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
